// File: rtl/axi_read.sv
// AXI4 read master: fetches BURST_NUM INCR bursts of AR_LEN beats from
// BASE_ADDR and streams the beats out byte-reversed through one register stage.
//
// state   | meaning
// --------+---------------------------------------------------------------
// RD_IDLE | waiting for start; rd_err from the previous job is still visible
// RD_ADDR | presenting one AR request, address held until arready
// RD_DATA | accepting R beats for the current burst into the output register
// RD_DONE | waiting for the output register to drain, then pulsing done
module axi_read #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    AR_LEN     = 16,
    parameter int                    BURST_NUM  = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h1000_0000)
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_areset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_err,
    output logic                  m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic                  m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] M_RD_tdata,
    output logic                  M_RD_tvalid,
    output logic                  M_RD_tlast,
    input  logic                  M_RD_tready
);

    localparam int                    NBYTES      = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(AR_LEN * NBYTES);
    localparam logic [7:0]            LAST_BEAT   = 8'(AR_LEN - 1);
    localparam logic [15:0]           LAST_BURST  = 16'(BURST_NUM - 1);

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_DATA,
        RD_DONE
    } rd_state_t;

    rd_state_t             state;
    rd_state_t             state_next;
    logic [7:0]            beat_cnt;
    logic [15:0]           burst_cnt;
    logic                  beat_last;
    logic                  burst_last;
    logic                  r_hs;
    logic [DATA_WIDTH-1:0] rdata_rev;
    logic                  unused_rid;

    // Fixed AR attributes: single-ID INCR bursts of full bus width.
    assign m_axi_arid    = 1'b0;
    assign m_axi_arlen   = LAST_BEAT;
    assign m_axi_arsize  = 3'($clog2(NBYTES));
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd3;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arqos   = 4'd0;

    // Only one ID is ever issued, so the returned ID carries no information.
    assign unused_rid = m_axi_rid;

    assign beat_last  = (beat_cnt == LAST_BEAT);
    assign burst_last = (burst_cnt == LAST_BURST);
    assign r_hs       = m_axi_rvalid & m_axi_rready;

    // Byte 0 of the AXI beat lands in the most significant byte of the stream.
    always_comb begin
        rdata_rev = '0;
        for (int i = 0; i < NBYTES; i++) begin
            rdata_rev[8*(NBYTES-1-i) +: 8] = m_axi_rdata[8*i +: 8];
        end
    end

    // State register.
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state <= RD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; the burst ends on the counted beat, not on rlast.
    always_comb begin
        state_next    = state;
        busy          = 1'b1;
        done          = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state)
            RD_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = RD_ADDR;
                end
            end
            RD_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                m_axi_rready = ~M_RD_tvalid | M_RD_tready;
                if (m_axi_rvalid && m_axi_rready && beat_last) begin
                    state_next = burst_last ? RD_DONE : RD_ADDR;
                end
            end
            RD_DONE: begin
                if (!M_RD_tvalid) begin
                    done       = 1'b1;
                    state_next = RD_IDLE;
                end
            end
            default: state_next = RD_IDLE;
        endcase
    end

    // Counters, burst address and the sticky error flag.
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            beat_cnt     <= '0;
            burst_cnt    <= '0;
            m_axi_araddr <= BASE_ADDR;
            rd_err       <= 1'b0;
        end else begin
            if (state == RD_IDLE && start) begin
                beat_cnt     <= '0;
                burst_cnt    <= '0;
                m_axi_araddr <= BASE_ADDR;
                rd_err       <= 1'b0;
            end
            if (r_hs) begin
                if (m_axi_rresp != 2'b00 || m_axi_rlast != beat_last) begin
                    rd_err <= 1'b1;
                end
                if (beat_last) begin
                    beat_cnt <= '0;
                    if (!burst_last) begin
                        burst_cnt    <= burst_cnt + 16'd1;
                        m_axi_araddr <= m_axi_araddr + BURST_BYTES;
                    end
                end else begin
                    beat_cnt <= beat_cnt + 8'd1;
                end
            end
        end
    end

    // Output register: load on every R beat, drain on tready; both at once keeps it full.
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            M_RD_tdata  <= '0;
            M_RD_tvalid <= 1'b0;
            M_RD_tlast  <= 1'b0;
        end else if (r_hs) begin
            M_RD_tdata  <= rdata_rev;
            M_RD_tvalid <= 1'b1;
            M_RD_tlast  <= beat_last;
        end else if (M_RD_tvalid && M_RD_tready) begin
            M_RD_tvalid <= 1'b0;
            M_RD_tlast  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_read.sv
// Directed bench for axi_read: full-throughput job, stream back-pressure,
// slow arready, error response, and reset mid-burst, with a small AXI slave model.
module tb_axi_read;

    logic        clk = 1'b0;
    logic        m_axi_areset;
    logic        start;
    logic        busy;
    logic        done;
    logic        rd_err;
    logic        m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic [3:0]  m_axi_arqos;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic        m_axi_rid;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [63:0] M_RD_tdata;
    logic        M_RD_tvalid;
    logic        M_RD_tlast;
    logic        M_RD_tready;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    axi_read dut (
        .m_axi_aclk    (clk),
        .m_axi_areset  (m_axi_areset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .rd_err        (rd_err),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arlock  (m_axi_arlock),
        .m_axi_arcache (m_axi_arcache),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arqos   (m_axi_arqos),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rid     (m_axi_rid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .M_RD_tdata    (M_RD_tdata),
        .M_RD_tvalid   (M_RD_tvalid),
        .M_RD_tlast    (M_RD_tlast),
        .M_RD_tready   (M_RD_tready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Beat g of a job; beat 0 is the reference pattern 0011223344556677.
    function automatic logic [63:0] data_of(input int g);
        return 64'h0011_2233_4455_6677 + 64'(g) * 64'h0101_0101_0101_0101;
    endfunction

    function automatic logic [63:0] rev(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*(7-i) +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic idle_inputs();
        start         = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        m_axi_rid     = 1'b0;
        M_RD_tready   = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arvalid"}, 64'(m_axi_arvalid), 64'd0);
        check({tag, "_rready"},  64'(m_axi_rready),  64'd0);
        check({tag, "_tvalid"},  64'(M_RD_tvalid),   64'd0);
        check({tag, "_tlast"},   64'(M_RD_tlast),    64'd0);
        check({tag, "_busy"},    64'(busy),          64'd0);
        check({tag, "_done"},    64'(done),          64'd0);
        check({tag, "_rd_err"},  64'(rd_err),        64'd0);
        check({tag, "_araddr"},  64'(m_axi_araddr),  64'h1000_0000);
    endtask

    // One read job against a slave model. ar_delay: arvalid cycles before arready.
    // toggle: tready alternates 1/0. err_b/err_k: burst/beat answered with SLVERR.
    // rst_bu/rst_k: burst/beat on which reset is asserted (-1 = none).
    task automatic run_job(input int ar_delay, input bit toggle, input int err_b, input int err_k,
                           input int rst_bu, input int rst_k, input bit exp_err_before);
        int          burst = 0, beat = 0, ar_wait = 0, beats_out = 0, dones = 0, n_ar = 0, cyc = 0;
        int          prev_g = -1;
        bit          active = 0, prev_rhs = 0, prev_last = 0, prev_stall = 0, held_last = 0;
        bit          err_flag = 0, aborted = 0;
        logic [63:0] prev_rdata = '0, held_data = '0;

        @(posedge clk); #1;
        start = 1'b1;
        #1;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_rready", 64'(m_axi_rready), 64'd0);
        check("err_before_start", 64'(rd_err), 64'(exp_err_before));
        @(posedge clk); #1;
        start = 1'b0;

        while (dones == 0 && cyc < 3000) begin
            cyc++;
            if (m_axi_arvalid) ar_wait++;
            m_axi_arready = m_axi_arvalid && (ar_wait > ar_delay);
            m_axi_rvalid  = active;
            m_axi_rdata   = data_of(burst * 16 + beat);
            m_axi_rresp   = (active && burst == err_b && beat == err_k) ? 2'b10 : 2'b00;
            m_axi_rlast   = active && (beat == 15);
            M_RD_tready   = toggle ? cyc[0] : 1'b1;
            if (rst_bu >= 0 && active && burst == rst_bu && beat == rst_k) begin
                m_axi_areset = 1'b1;
                aborted      = 1;
            end
            #1;
            check("busy", 64'(busy), 64'd1);
            check("rd_err", 64'(rd_err), 64'(err_flag));
            if (prev_rhs) begin
                check("lat_valid", 64'(M_RD_tvalid), 64'd1);
                check("lat_data", M_RD_tdata, rev(prev_rdata));
                check("lat_last", 64'(M_RD_tlast), 64'(prev_last));
                if (prev_g == 0) check("byte_rev_const", M_RD_tdata, 64'h7766_5544_3322_1100);
            end
            if (prev_stall) begin
                check("stall_valid", 64'(M_RD_tvalid), 64'd1);
                check("stall_data", M_RD_tdata, held_data);
                check("stall_last", 64'(M_RD_tlast), 64'(held_last));
            end
            if (M_RD_tvalid && !M_RD_tready) check("rready_full", 64'(m_axi_rready), 64'd0);
            if (m_axi_arvalid) begin
                check("araddr", 64'(m_axi_araddr), 64'(32'h1000_0000 + 32'(burst) * 32'h80));
                check("rready_in_addr", 64'(m_axi_rready), 64'd0);
            end
            if (done) begin
                dones++;
                check("done_empty", 64'(M_RD_tvalid), 64'd0);
                check("beats_at_done", 64'(beats_out), 64'd64);
                check("bursts_at_done", 64'(n_ar), 64'd4);
            end
            if (M_RD_tvalid && M_RD_tready) begin
                check("t_data", M_RD_tdata, rev(data_of(beats_out)));
                check("t_last", 64'(M_RD_tlast), 64'((beats_out % 16) == 15));
                beats_out++;
            end
            prev_stall = M_RD_tvalid && !M_RD_tready;
            held_data  = M_RD_tdata;
            held_last  = M_RD_tlast;
            prev_rhs   = m_axi_rvalid && m_axi_rready;
            if (prev_rhs) begin
                prev_rdata = m_axi_rdata;
                prev_last  = (beat == 15);
                prev_g     = burst * 16 + beat;
                if (m_axi_rresp != 2'b00) err_flag = 1;
                beat++;
                if (beat == 16) begin
                    beat   = 0;
                    burst++;
                    active = 0;
                end
            end
            if (m_axi_arvalid && m_axi_arready) begin
                check("ar_wait", 64'(ar_wait), 64'(ar_delay + 1));
                active  = 1;
                ar_wait = 0;
                n_ar++;
            end
            @(posedge clk); #1;
            if (aborted) break;
        end

        if (aborted) begin
            check_reset_outputs("abort");
            check("no_done_abort", 64'(dones), 64'd0);
            m_axi_areset = 1'b0;
            idle_inputs();
        end else begin
            check("done_seen", 64'(dones), 64'd1);
            idle_inputs();
            check("post_busy", 64'(busy), 64'd0);
            check("post_done", 64'(done), 64'd0);
            check("post_arvalid", 64'(m_axi_arvalid), 64'd0);
            check("post_rready", 64'(m_axi_rready), 64'd0);
            check("post_tvalid", 64'(M_RD_tvalid), 64'd0);
            check("post_rd_err", 64'(rd_err), 64'(err_flag));
        end
    endtask

    initial begin
        idle_inputs();
        m_axi_areset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("arid",    64'(m_axi_arid),    64'd0);
        check("arlen",   64'(m_axi_arlen),   64'd15);
        check("arsize",  64'(m_axi_arsize),  64'd3);
        check("arburst", 64'(m_axi_arburst), 64'd1);
        check("arlock",  64'(m_axi_arlock),  64'd0);
        check("arcache", 64'(m_axi_arcache), 64'd3);
        check("arprot",  64'(m_axi_arprot),  64'd0);
        check("arqos",   64'(m_axi_arqos),   64'd0);
        m_axi_areset = 1'b0;

        // Full throughput, four bursts from the base address.
        run_job(0, 1'b0, -1, -1, -1, -1, 1'b0);
        // Stream back-pressure: tready alternates every cycle.
        run_job(0, 1'b1, -1, -1, -1, -1, 1'b0);
        // arready arrives only after arvalid has been held for five cycles.
        run_job(5, 1'b0, -1, -1, -1, -1, 1'b0);
        // SLVERR on beat 3 of burst 0; flag stays set through done.
        run_job(0, 1'b0, 0, 3, -1, -1, 1'b0);
        // Reset on beat 8 of burst 1; the new start clears the stale error first.
        run_job(0, 1'b0, -1, -1, 1, 8, 1'b1);
        // Restart after the abort must begin again at the base address.
        run_job(0, 1'b0, -1, -1, -1, -1, 1'b0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
